mem_access_ctrl: RTL and testbench

Multicycle sequencer for the MEM stage. It accepts one load/store request from the main control FSM and checks alignment. It then drives a word-addressed data memory through a req/ready handshake with byte enables, performs byte/halfword lane selection and sign/zero extension of load data, and reports completion, alignment faults or timeouts back to the control FSM.

---
 rtl/mem_access_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, req/ready memory handshake,
// byte-lane steering for stores and lane select plus sign/zero extension for loads.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] ld_data,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic        timeout
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [TO_W-1:0] TO_SAT = TO_W'(TIMEOUT);
  localparam logic [TO_W:0]   TO_LIM = (TO_W+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, FINISH, FAULT} state_t;

  state_t          state, state_nxt;
  logic [5:0]      op_q;
  logic [1:0]      off_q;
  logic            to_flag;
  logic [TO_W-1:0] wait_cnt;

  logic        legal, misaligned, accept, to_hit;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;

  // opcode decode, alignment check and store lane steering
  always_comb begin
    legal      = 1'b1;
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wd_calc    = st_data;
    case (op)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: misaligned = addr[0];
      OP_LW:         misaligned = |addr[1:0];
      OP_SB: begin
        be_calc = 4'b0001 << addr[1:0];
        wd_calc = {4{st_data[7:0]}};
      end
      OP_SH: begin
        misaligned = addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wd_calc    = {2{st_data[15:0]}};
      end
      OP_SW:   misaligned = |addr[1:0];
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == IDLE) && start && legal;

  // +1 compare in a wider width keeps TIMEOUT-1 from underflowing when TIMEOUT=0
  assign to_hit = (TIMEOUT != 0) && !mem_ready &&
                  (({1'b0, wait_cnt} + (TO_W+1)'(1)) == TO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = misaligned ? FAULT : ACCESS;
      ACCESS:  if (mem_ready || to_hit) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == ACCESS);
    busy     = (state != IDLE);
    done     = (state == FINISH) || (state == FAULT);
    addr_err = (state == FAULT);
    timeout  = (state == FINISH) && to_flag;
  end

  // memory-side fields are frozen at acceptance so they stay stable through ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
      op_q      <= '0;
      off_q     <= '0;
    end else if (accept) begin
      mem_addr  <= {addr[31:2], 2'b00};
      mem_we    <= op[3];
      mem_be    <= be_calc;
      mem_wdata <= wd_calc;
      op_q      <= op;
      off_q     <= addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (accept) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (state == ACCESS) begin
      if (!mem_ready && wait_cnt != TO_SAT) wait_cnt <= wait_cnt + 1'b1;
      if (to_hit) to_flag <= 1'b1;
    end
  end

  // load lane select and extension
  always_comb begin
    lane_b = mem_rdata[8*off_q +: 8];
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_ext = {24'd0, lane_b};
      OP_LH:   ld_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_ext = {16'd0, lane_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ld_data <= '0;
    else if (state == ACCESS && mem_ready && !op_q[3])
      ld_data <= ld_ext;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed test-plan cases plus randomized accesses
// checked against a byte-arithmetic reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  op;
  logic [31:0] addr, st_data, mem_rdata;
  logic        mem_ready;
  logic        mem_req, mem_we, busy, done, addr_err, timeout;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, ld_data;

  int checks = 0;
  int errors = 0;

  int          obs_done_at, obs_req_n;
  logic [3:0]  obs_be;
  logic        obs_we, obs_stable, obs_ae, obs_to;
  logic [31:0] obs_maddr, obs_wdata;
  logic [31:0] exp_ld;

  logic [5:0] ops [8] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                          6'b100101, 6'b101000, 6'b101001, 6'b101011};

  mem_access_ctrl #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .addr(addr),
    .st_data(st_data), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ld_data(ld_data), .busy(busy), .done(done),
    .addr_err(addr_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // reference: size in bytes from op[1:0], natural-alignment fault, shift/mask lane extraction
  function automatic void model(input logic [5:0] o, input logic [31:0] a, sd, rd,
                                output logic fault, output logic is_st, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] ld);
    int n, off;
    logic [31:0] mask, v;
    n     = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
    is_st = o[3];
    fault = (int'(a[1:0]) % n) != 0;
    off   = int'(a[1:0]) / n * n;
    mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    v     = (rd >> (8*off)) & mask;
    if (!o[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    ld = v;
    be = is_st ? 4'(((1 << n) - 1) << off) : 4'hF;
    wd = (n == 1) ? {4{sd[7:0]}} : (n == 2) ? {2{sd[15:0]}} : sd;
  endfunction

  // drives one start and records what the DUT did; waits<0 means mem_ready never comes
  task automatic run_access(input logic [5:0] o, input logic [31:0] a, sd, rd, input int waits);
    logic first;
    @(negedge clk);
    start = 1'b1; op = o; addr = a; st_data = sd; mem_rdata = rd; mem_ready = 1'b0;
    obs_done_at = -1; obs_req_n = 0; obs_stable = 1'b1; obs_ae = 1'b0; obs_to = 1'b0;
    obs_be = '0; obs_we = 1'b0; obs_maddr = '0; obs_wdata = '0; first = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b0;
      if (mem_req) begin
        if (first) begin
          obs_be = mem_be; obs_we = mem_we; obs_maddr = mem_addr; obs_wdata = mem_wdata;
          first = 1'b0;
        end else if (obs_be !== mem_be || obs_we !== mem_we || obs_maddr !== mem_addr ||
                     obs_wdata !== mem_wdata) obs_stable = 1'b0;
        obs_req_n++;
        mem_ready = (waits >= 0) && (obs_req_n == waits + 1);
      end
      if (done) begin
        obs_done_at = c; obs_ae = addr_err; obs_to = timeout;
        break;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; st_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    exp_ld = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, busy, done, addr_err, timeout, mem_we} !== 6'b0 || mem_be !== 4'b0 ||
        mem_addr !== 32'b0 || mem_wdata !== 32'b0 || ld_data !== 32'b0) begin
      errors++;
      $display("FAIL reset_state req=%b busy=%b done=%b be=%h addr=%h ld=%h (all must be 0)",
               mem_req, busy, done, mem_be, mem_addr, ld_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loads;
    run_access(6'b100000, 32'h13, 32'h0, 32'h80AB_CDEF, 0);
    exp_ld = 32'hFFFF_FF80;
    checks++;
    if (obs_done_at != 2 || obs_req_n != 1) begin
      errors++; $display("FAIL lb_latency done_at=%0d req=%0d want 2/1", obs_done_at, obs_req_n);
    end
    checks++;
    if (obs_maddr !== 32'h10 || obs_be !== 4'hF || obs_we !== 1'b0) begin
      errors++; $display("FAIL lb_bus addr=%h be=%b we=%b want 10/1111/0", obs_maddr, obs_be, obs_we);
    end
    checks++;
    if (ld_data !== exp_ld) begin errors++; $display("FAIL lb_data got %h want %h", ld_data, exp_ld); end
    run_access(6'b100101, 32'h22, 32'h0, 32'h8001_7FFF, 0);
    exp_ld = 32'h0000_8001;
    checks++;
    if (ld_data !== exp_ld) begin errors++; $display("FAIL lhu_data got %h want %h", ld_data, exp_ld); end
    run_access(6'b100001, 32'h20, 32'h0, 32'h8001_7FFF, 1);
    exp_ld = 32'h0000_7FFF;
    checks++;
    if (ld_data !== exp_ld || obs_done_at != 3) begin
      errors++; $display("FAIL lh_data got %h/%0d want %h/3", ld_data, obs_done_at, exp_ld);
    end
  endtask

  task automatic test_store;
    run_access(6'b101000, 32'h41, 32'h1234_56A5, 32'hDEAD_BEEF, 3);
    checks++;
    if (obs_we !== 1'b1 || obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5 || obs_maddr !== 32'h40) begin
      errors++;
      $display("FAIL sb_bus we=%b be=%b wd=%h addr=%h want 1/0010/a5a5a5a5/40", obs_we, obs_be, obs_wdata, obs_maddr);
    end
    checks++;
    if (obs_stable !== 1'b1 || obs_req_n != 4 || obs_done_at != 5) begin
      errors++;
      $display("FAIL sb_timing stable=%b req=%0d done_at=%0d want 1/4/5", obs_stable, obs_req_n, obs_done_at);
    end
    checks++;
    if (ld_data !== exp_ld) begin errors++; $display("FAIL sb_ld_hold got %h want %h", ld_data, exp_ld); end
  endtask

  task automatic test_faults;
    run_access(6'b101011, 32'h6, 32'h0, 32'h0, 0);
    checks++;
    if (obs_done_at != 1 || obs_req_n != 0 || obs_ae !== 1'b1 || obs_to !== 1'b0) begin
      errors++;
      $display("FAIL sw_fault done_at=%0d req=%0d ae=%b want 1/0/1", obs_done_at, obs_req_n, obs_ae);
    end
    run_access(6'b100001, 32'h3, 32'h0, 32'h0, 0);
    checks++;
    if (obs_done_at != 1 || obs_req_n != 0 || obs_ae !== 1'b1 || ld_data !== exp_ld) begin
      errors++;
      $display("FAIL lh_fault done_at=%0d req=%0d ae=%b ld=%h", obs_done_at, obs_req_n, obs_ae, ld_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || addr_err !== 1'b0) begin
      errors++; $display("FAIL fault_one_shot busy=%b ae=%b want 0/0", busy, addr_err);
    end
  endtask

  task automatic test_timeout;
    run_access(6'b100011, 32'h100, 32'h0, 32'h5555_AAAA, -1);
    checks++;
    if (obs_req_n != 4 || obs_done_at != 5 || obs_to !== 1'b1 || obs_ae !== 1'b0) begin
      errors++;
      $display("FAIL timeout req=%0d done_at=%0d to=%b want 4/5/1", obs_req_n, obs_done_at, obs_to);
    end
    checks++;
    if (ld_data !== exp_ld) begin errors++; $display("FAIL timeout_ld got %h want %h", ld_data, exp_ld); end
  endtask

  task automatic test_illegal_op;
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; op = 6'b000000; addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (busy || done || mem_req) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL illegal_op active_cycles=%0d want 0", seen); end
  endtask

  task automatic test_back_to_back;
    run_access(6'b100011, 32'h8, 32'h0, 32'h0BAD_F00D, 0);
    exp_ld = 32'h0BAD_F00D;
    start = 1'b1; op = 6'b101011; addr = 32'h0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || ld_data !== exp_ld) begin
      errors++; $display("FAIL start_in_finish busy=%b ld=%h want 0/%h", busy, ld_data, exp_ld);
    end
    run_access(6'b101001, 32'h2, 32'hCAFE_1234, 32'h0, 0);
    checks++;
    if (obs_done_at != 2 || obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234) begin
      errors++;
      $display("FAIL sh_after be=%b wd=%h done_at=%0d want 1100/12341234/2", obs_be, obs_wdata, obs_done_at);
    end
  endtask

  task automatic test_random;
    logic [5:0]  o;
    logic [31:0] a, sd, rd, wd, ld;
    logic [3:0]  be;
    logic        fault, is_st;
    int          w;
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 7)];
      a = $urandom; sd = $urandom; rd = $urandom;
      w = $urandom_range(0, 3);
      model(o, a, sd, rd, fault, is_st, be, wd, ld);
      run_access(o, a, sd, rd, w);
      checks++;
      if (fault) begin
        if (obs_done_at != 1 || obs_req_n != 0 || obs_ae !== 1'b1) begin
          errors++;
          $display("FAIL rnd_fault op=%b a=%h done_at=%0d req=%0d ae=%b", o, a, obs_done_at, obs_req_n, obs_ae);
        end
      end else begin
        if (!is_st) exp_ld = ld;
        if (obs_done_at != w + 2 || obs_req_n != w + 1 || obs_ae !== 1'b0 || obs_to !== 1'b0 ||
            obs_stable !== 1'b1 || obs_be !== be || obs_we !== is_st ||
            obs_maddr !== {a[31:2], 2'b00} || (is_st && obs_wdata !== wd) || ld_data !== exp_ld) begin
          errors++;
          $display("FAIL rnd_access op=%b a=%h be=%b/%b wd=%h/%h ld=%h/%h done_at=%0d/%0d",
                   o, a, obs_be, be, obs_wdata, wd, ld_data, exp_ld, obs_done_at, w + 2);
        end
      end
    end
  endtask

  task automatic test_async_reset;
    int dones;
    @(negedge clk);
    start = 1'b1; op = 6'b100011; addr = 32'h30; mem_rdata = 32'h1111_2222; mem_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || ld_data !== 32'b0) begin
      errors++; $display("FAIL async_reset req=%b busy=%b ld=%h want 0/0/0", mem_req, busy, ld_data);
    end
    exp_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 6'b100011; addr = 32'h44; mem_rdata = 32'h7654_3210;
    @(negedge clk);
    start = 1'b1; op = 6'b100000; addr = 32'h45;
    mem_ready = 1'b1;
    dones = 0;
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 1 || ld_data !== 32'h7654_3210) begin
      errors++; $display("FAIL busy_start dones=%0d ld=%h want 1/76543210", dones, ld_data);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_store;
    test_faults;
    test_timeout;
    test_illegal_op;
    test_back_to_back;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
